divclk_mon: RTL and testbench
=============================

Name: divclk_mon

Overview:
- Frequency/period monitor for divided or gated clocks (e.g. divff_8, divff_5, clk_500) and external slow strobes.
- Sits in the mclk domain and is the consumer of the divider chain's outputs.
- Synchronises a slow input, measures its period in mclk cycles, and checks the period against a programmable window.
- Raises sticky fast, slow and stuck error flags for the chip watchdog and for test logic.

Parameters:
CNT_W, 16, width of the period counter, limits and result
SYNC_STG, 2, number of synchroniser flops on clk_in (minimum 2)

Ports:
mclk  input  1  system clock
srstz  input  1  asynchronous active-low reset
en  input  1  monitor enable, level
clk_in  input  1  monitored signal, asynchronous to mclk
lo_lim  input  CNT_W  minimum legal period in mclk cycles, quasi-static
hi_lim  input  CNT_W  maximum legal period in mclk cycles, quasi-static
clr_err  input  1  one-cycle pulse; clears the sticky error flags
period  output  CNT_W  last measured period in mclk cycles
period_vld  output  1  one-cycle pulse when period updates
err_fast  output  1  sticky: measured period < lo_lim
err_slow  output  1  sticky: measured period > hi_lim
err_stuck  output  1  sticky: counter saturated with no edge
busy  output  1  high in ARM or MEAS

Behaviour:
- Reset is srstz, asynchronous, active-low; clock is mclk.
- Reset values:
  - all outputs 0, period = 0
  - synchroniser flops 0, counter 0, state IDLE
- Synchroniser:
  - SYNC_STG-flop chain on clk_in, plus one delay flop.
  - rise = sync_out & ~sync_dly, a single mclk cycle wide.
- Counter cnt (CNT_W bits):
  - increments by 1 every cycle in ARM and MEAS.
  - saturates at 2^CNT_W-1 and never wraps.
- FSM states are IDLE, ARM and MEAS.
  - IDLE: cnt = 0. When en=1, go to ARM next cycle with cnt = 0.
  - ARM: waits for the first rise. No measurement is taken on this rise.
    - On rise: go to MEAS, cnt <= 1.
    - On saturation without a rise: set err_stuck, stay in ARM, cnt <= 0.
  - MEAS, on rise:
    - period <= cnt and period_vld = 1 on the next cycle.
    - err_fast set if cnt < lo_lim; err_slow set if cnt > hi_lim (unsigned compares on the value at the rise cycle).
    - cnt <= 1, stay in MEAS.
  - MEAS, on saturation without a rise: set err_stuck, go to ARM, cnt <= 0. The partial measurement is discarded and period is unchanged.
  - Any state, en=0: go to IDLE next cycle and clear cnt.
    - en takes priority over a coincident rise.
    - period and the error flags hold their values.
- Period semantics: a square wave of N mclk cycles reports period = N. Example: divff_8 reports 8.
- Latency: clk_in rising edge to period_vld is SYNC_STG+2 mclk cycles (±1 cycle of synchroniser uncertainty).
- Error flags:
  - Sticky until a clr_err pulse.
  - If clr_err and a set condition occur in the same cycle, set wins.
  - clr_err does not affect period, the FSM or cnt.
- Limits:
  - lo_lim > hi_lim is legal. Both checks apply independently, so every edge flags an error.
  - lo_lim = 0 disables the fast check. hi_lim = 2^CNT_W-1 disables the slow check.
- busy = (state != IDLE).
- Reset mid-measurement: all state returns to reset values immediately. The first rise after release re-arms only; it produces no period_vld.

Decomposition:
- Package divclk_mon_pkg:
  - state enum {IDLE, ARM, MEAS}
  - CNT_W default
  - CNT_MAX constant function of CNT_W
- Sub-module divclk_mon_sync:
  - SYNC_STG flop chain, delay flop and rise pulse output.
  - Reused by the other clock monitors.
- The FSM, counter, comparators and flags stay in the top module.

Test Plan:
- en=1, clk_in a square wave with period 8 mclk, lo=7, hi=9 -> after the first (arming) edge, period=8 with period_vld every 8 cycles; no error flags.
- Same limits, period 4 -> first measurement sets err_fast=1 with period=4; err_slow and err_stuck remain 0.
- Same limits, period 12 -> err_slow=1 with period=12. Pulse clr_err between edges -> flag clears, then re-sets at the next edge.
- CNT_W=8, clk_in held low, en=1 -> err_stuck=1 exactly 256 cycles after entering ARM; busy stays 1; no period_vld.
- clr_err asserted in the same cycle as an err_fast set condition -> err_fast=1 afterwards.
- Mid-MEAS srstz low for 1 cycle -> all outputs 0. Next edge produces no period_vld; the second edge produces a correct period. Drop en mid-MEAS -> IDLE next cycle, busy=0, period is held.

Source files
------------

// File: rtl/divclk_mon_pkg.sv
// Shared types and constants for the divided-clock period monitor family.
package divclk_mon_pkg;

  typedef enum logic [1:0] {StIdle, StArm, StMeas} state_e;

  localparam int unsigned CntWDefault = 16;

  // All-ones value of a counter of the given width (saturation point).
  function automatic int unsigned cnt_max(input int unsigned width);
    return (width >= 32) ? 32'hffff_ffff : (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/divclk_mon_sync.sv
// Multi-flop synchroniser for a slow asynchronous signal with a one-cycle rising-edge pulse.
module divclk_mon_sync #(
  parameter int unsigned SYNC_STG = 2
) (
  input  logic mclk,
  input  logic srstz,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STG-1:0] sync_q;
  logic                dly_q;

  always_ff @(posedge mclk or negedge srstz) begin
    if (!srstz) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STG-2:0], async_in};
      dly_q  <= sync_q[SYNC_STG-1];
    end
  end

  assign rise = sync_q[SYNC_STG-1] & ~dly_q;

endmodule

// File: rtl/divclk_mon.sv
// Period monitor: measures the mclk-cycle spacing of clk_in rising edges and flags
// periods outside [lo_lim, hi_lim] or a missing edge (counter saturation).
module divclk_mon
  import divclk_mon_pkg::*;
#(
  parameter int unsigned CNT_W    = CntWDefault,
  parameter int unsigned SYNC_STG = 2
) (
  input  logic             mclk,
  input  logic             srstz,
  input  logic             en,
  input  logic             clk_in,
  input  logic [CNT_W-1:0] lo_lim,
  input  logic [CNT_W-1:0] hi_lim,
  input  logic             clr_err,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             err_fast,
  output logic             err_slow,
  output logic             err_stuck,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(cnt_max(CNT_W));
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             vld_q, vld_d;
  logic             fast_q, fast_d, slow_q, slow_d, stuck_q, stuck_d;
  logic             rise, sat, set_fast, set_slow, set_stuck;

  divclk_mon_sync #(
    .SYNC_STG(SYNC_STG)
  ) u_sync (
    .mclk    (mclk),
    .srstz   (srstz),
    .async_in(clk_in),
    .rise    (rise)
  );

  assign sat = (cnt_q == CntMax);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    vld_d     = 1'b0;
    set_fast  = 1'b0;
    set_slow  = 1'b0;
    set_stuck = 1'b0;
    // Disabling wins over any coincident edge.
    if (!en) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StArm;
          cnt_d   = '0;
        end
        StArm: begin
          if (rise) begin
            state_d = StMeas;
            cnt_d   = CntOne;
          end else if (sat) begin
            set_stuck = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StMeas: begin
          if (rise) begin
            period_d = cnt_q;
            vld_d    = 1'b1;
            set_fast = (cnt_q < lo_lim);
            set_slow = (cnt_q > hi_lim);
            cnt_d    = CntOne;
          end else if (sat) begin
            // Partial measurement is dropped; re-arm on the next edge.
            set_stuck = 1'b1;
            state_d   = StArm;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Set has priority over a coincident clear.
  always_comb begin
    fast_d  = set_fast  | (fast_q  & ~clr_err);
    slow_d  = set_slow  | (slow_q  & ~clr_err);
    stuck_d = set_stuck | (stuck_q & ~clr_err);
  end

  always_ff @(posedge mclk or negedge srstz) begin
    if (!srstz) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      period_q <= '0;
      vld_q    <= 1'b0;
      fast_q   <= 1'b0;
      slow_q   <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      vld_q    <= vld_d;
      fast_q   <= fast_d;
      slow_q   <= slow_d;
      stuck_q  <= stuck_d;
    end
  end

  assign period     = period_q;
  assign period_vld = vld_q;
  assign err_fast   = fast_q;
  assign err_slow   = slow_q;
  assign err_stuck  = stuck_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_divclk_mon.sv
// Bench for divclk_mon: edge-time reference model compared against reported periods and flags.
module tb_divclk_mon;

  localparam int unsigned CntW    = 8;
  localparam int unsigned SyncStg = 2;

  logic            mclk = 1'b0;
  logic            srstz = 1'b0;
  logic            en = 1'b0;
  logic            clk_in = 1'b0;
  logic            clr_err = 1'b0;
  logic [CntW-1:0] lo_lim = '0;
  logic [CntW-1:0] hi_lim = '1;
  logic [CntW-1:0] period;
  logic            period_vld, err_fast, err_slow, err_stuck, busy;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int obs_p[$];
  int obs_t[$];
  int rise_t[$];
  int gaps[16];

  divclk_mon #(
    .CNT_W   (CntW),
    .SYNC_STG(SyncStg)
  ) dut (
    .mclk      (mclk),
    .srstz     (srstz),
    .en        (en),
    .clk_in    (clk_in),
    .lo_lim    (lo_lim),
    .hi_lim    (hi_lim),
    .clr_err   (clr_err),
    .period    (period),
    .period_vld(period_vld),
    .err_fast  (err_fast),
    .err_slow  (err_slow),
    .err_stuck (err_stuck),
    .busy      (busy)
  );

  always #5 mclk = ~mclk;

  always @(posedge mclk) cyc <= cyc + 1;

  always @(negedge mclk) begin
    if (period_vld === 1'b1) begin
      obs_p.push_back(int'(period));
      obs_t.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clk_in period of p mclk cycles starting with a rising edge.
  task automatic emit(input int p);
    rise_t.push_back(cyc);
    clk_in = 1'b1;
    repeat (p / 2) tick();
    clk_in = 1'b0;
    repeat (p - p / 2) tick();
  endtask

  task automatic start_phase(input int lo, input int hi);
    en = 1'b0;
    repeat (3) tick();
    lo_lim  = CntW'(lo);
    hi_lim  = CntW'(hi);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    obs_p.delete();
    obs_t.delete();
    rise_t.delete();
    en = 1'b1;
    repeat (2) tick();
  endtask

  // Expected periods are the spacings of consecutive rising edges; the first edge only arms.
  task automatic check_phase(input string tag, input int lo, input int hi);
    bit ef, es;
    int d;
    ef = 1'b0;
    es = 1'b0;
    repeat (SyncStg + 3) tick();
    check($sformatf("%s count", tag), obs_p.size(), rise_t.size() - 1);
    for (int i = 1; i < rise_t.size(); i++) begin
      d = rise_t[i] - rise_t[i-1];
      if (d < lo) ef = 1'b1;
      if (d > hi) es = 1'b1;
      if (i - 1 < obs_p.size()) begin
        check($sformatf("%s period[%0d]", tag, i - 1), obs_p[i-1], d);
        if (i > 1) check($sformatf("%s spacing[%0d]", tag, i - 1), obs_t[i-1] - obs_t[i-2], d);
      end
    end
    check($sformatf("%s err_fast", tag), err_fast, ef);
    check($sformatf("%s err_slow", tag), err_slow, es);
    check($sformatf("%s err_stuck", tag), err_stuck, 0);
  endtask

  task automatic run_phase(input string tag, input int lo, input int hi, input int n);
    start_phase(lo, hi);
    for (int i = 0; i < n; i++) emit(gaps[i]);
    check_phase(tag, lo, hi);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " period"}, period, 0);
    check({tag, " period_vld"}, period_vld, 0);
    check({tag, " err_fast"}, err_fast, 0);
    check({tag, " err_slow"}, err_slow, 0);
    check({tag, " err_stuck"}, err_stuck, 0);
    check({tag, " busy"}, busy, 0);
  endtask

  initial begin
    int lo_r, hi_r, exp_p, t0, t_st, n_keep;
    bit busy_ok;

    repeat (3) tick();
    check_all_zero("reset");
    srstz = 1'b1;
    tick();

    // Nominal divff_8 style input inside the window.
    for (int i = 0; i < 16; i++) gaps[i] = 8;
    run_phase("p8", 7, 9, 6);

    for (int i = 0; i < 16; i++) gaps[i] = 4;
    run_phase("p4", 7, 9, 4);

    for (int i = 0; i < 16; i++) gaps[i] = 12;
    run_phase("p12", 7, 9, 3);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("p12 cleared", err_slow, 0);
    check("p12 period held over clr", period, 12);
    emit(12);
    repeat (SyncStg + 3) tick();
    check("p12 re-set", err_slow, 1);
    check("p12 count after clr", obs_p.size(), 3);
    if (obs_p.size() == 3) check("p12 late period", obs_p[2], rise_t[3] - rise_t[2]);

    // clr_err lands on the same cycle as the err_fast set condition.
    start_phase(7, 9);
    emit(4);
    rise_t.push_back(cyc);
    clk_in = 1'b1;
    repeat (SyncStg) tick();
    clr_err = 1'b1;
    clk_in  = 1'b0;
    tick();
    clr_err = 1'b0;
    repeat (4) tick();
    check("coincident err_fast", err_fast, 1);
    check("coincident count", obs_p.size(), 1);
    if (obs_p.size() == 1) check("coincident period", obs_p[0], rise_t[1] - rise_t[0]);

    for (int r = 0; r < 3; r++) begin
      lo_r = $urandom_range(20, 0);
      hi_r = $urandom_range(30, 5);
      if (r == 2) begin
        lo_r = 0;
        hi_r = 255;
      end
      for (int i = 0; i < 16; i++) gaps[i] = $urandom_range(40, 2);
      run_phase($sformatf("rand%0d", r), lo_r, hi_r, 7);
    end

    // Asynchronous reset in the middle of a measurement.
    start_phase(7, 9);
    for (int i = 0; i < 3; i++) emit(4);
    repeat (SyncStg + 3) tick();
    check("pre-reset err_fast", err_fast, 1);
    srstz = 1'b0;
    #1;
    check_all_zero("mid reset");
    tick();
    srstz = 1'b1;
    obs_p.delete();
    obs_t.delete();
    rise_t.delete();
    repeat (2) tick();
    emit(8);
    emit(8);
    repeat (SyncStg + 3) tick();
    check("post-reset count", obs_p.size(), 1);
    if (obs_p.size() == 1) check("post-reset period", obs_p[0], rise_t[1] - rise_t[0]);

    // Drop en while measuring: idle next cycle, period held, edges ignored.
    exp_p = rise_t[1] - rise_t[0];
    en = 1'b0;
    tick();
    check("en drop busy", busy, 0);
    check("en drop period", period, exp_p);
    n_keep = obs_p.size();
    emit(6);
    emit(6);
    repeat (5) tick();
    check("disabled count", obs_p.size(), n_keep);

    // Stuck: no edges at all; flag 2^CNT_W cycles after entering ARM.
    repeat (3) tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    obs_p.delete();
    obs_t.delete();
    t0 = -1;
    t_st = -1;
    busy_ok = 1'b1;
    en = 1'b1;
    for (int k = 0; k < 10 && t0 < 0; k++) begin
      tick();
      if (busy === 1'b1) t0 = cyc;
    end
    check("stuck armed", busy, 1);
    for (int k = 0; k < 400 && t_st < 0; k++) begin
      tick();
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (err_stuck === 1'b1) t_st = cyc;
    end
    check("stuck delay", t_st - t0, 256);
    check("stuck busy held", busy_ok, 1);
    check("stuck no vld", obs_p.size(), 0);
    check("stuck period held", period, exp_p);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
